// File: rtl/sdram_arbiter.sv
// Purpose : share one toggle-handshake SDRAM controller port among NUM_PORTS requesters;
//           port 0 has fixed priority (bounded by a hog limit), ports 1..N-1 rotate round-robin.
// Latency : grant one edge after a request becomes pending; requester ack one edge after mem_ack.
// Backpressure: one transaction outstanding; others wait on their pending bit (req_i != ack_o).
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   req_i/ack_o   per-port toggle handshake; a port is pending while its bits differ
//   addr_i, we_i, wdata_i   per-port request slices (held stable while pending)
//   rdata_o       per-port read-data holding registers
//   mem_req/mem_ack         toggle handshake to the SDRAM controller
//   mem_address/mem_we/mem_wdata  latched command of the port in service
//   mem_rdata     controller read data, valid when mem_ack == mem_req
//   grant_o       index of the port in service; busy_o high while outstanding
module sdram_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_BITS = 23,
   parameter int HOG_LIMIT = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PORTS-1:0]           req_i,
   output logic [NUM_PORTS-1:0]           ack_o,
   input  logic [NUM_PORTS*ADDR_BITS-1:0] addr_i,
   input  logic [NUM_PORTS-1:0]           we_i,
   input  logic [NUM_PORTS*16-1:0]        wdata_i,
   output logic [NUM_PORTS*16-1:0]        rdata_o,
   output logic                           mem_req,
   input  logic                           mem_ack,
   output logic [ADDR_BITS-1:0]           mem_address,
   output logic                           mem_we,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   output logic [2:0]                     grant_o,
   output logic                           busy_o
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                   state, state_nxt;
   logic [2:0]               rr_ptr, rr_ptr_nxt;
   logic [3:0]               hog_cnt, hog_cnt_nxt;

   logic [NUM_PORTS-1:0]     ack_nxt;
   logic [NUM_PORTS*16-1:0]  rdata_nxt;
   logic                     mem_req_nxt;
   logic [ADDR_BITS-1:0]     mem_address_nxt;
   logic                     mem_we_nxt;
   logic [15:0]              mem_wdata_nxt;
   logic [2:0]               grant_nxt;
   logic                     busy_nxt;

   logic [NUM_PORTS-1:0]     pend;
   logic                     others_pend;
   logic                     hog_hit;
   logic [2:0]               win;
   logic                     win_vld;
   logic [ADDR_BITS-1:0]     win_addr;
   logic                     win_we;
   logic [15:0]              win_wdata;

   assign pend        = req_i ^ ack_o;
   assign others_pend = |pend[NUM_PORTS-1:1];
   // Port 0 loses its priority only once it has used up its hog budget
   // and somebody else is actually waiting.
   assign hog_hit     = (hog_cnt == 4'(HOG_LIMIT)) && others_pend;

   // Winner selection. The round-robin search visits ports rr_ptr..N-1 then
   // wraps to 1; port 0 never takes part in the rotation.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      if (pend[0] && !hog_hit) begin
         win_vld = 1'b1;
      end else begin
         for (int i = 0; i < NUM_PORTS - 1; i++) begin
            for (int k = 1; k < NUM_PORTS; k++) begin
               if (!win_vld && pend[k] &&
                   (k == ((int'(rr_ptr) - 1 + i) % (NUM_PORTS - 1)) + 1)) begin
                  win     = 3'(k);
                  win_vld = 1'b1;
               end
            end
         end
      end
   end

   // Mux out the winner's command slice.
   always_comb begin
      win_addr  = '0;
      win_we    = 1'b0;
      win_wdata = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (win == 3'(k)) begin
            win_addr  = addr_i[k*ADDR_BITS +: ADDR_BITS];
            win_we    = we_i[k];
            win_wdata = wdata_i[k*16 +: 16];
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_nxt       = state;
      rr_ptr_nxt      = rr_ptr;
      hog_cnt_nxt     = hog_cnt;
      ack_nxt         = ack_o;
      rdata_nxt       = rdata_o;
      mem_req_nxt     = mem_req;
      mem_address_nxt = mem_address;
      mem_we_nxt      = mem_we;
      mem_wdata_nxt   = mem_wdata;
      grant_nxt       = grant_o;
      busy_nxt        = busy_o;

      case (state)
         IDLE: begin
            if (win_vld) begin
               mem_address_nxt = win_addr;
               mem_we_nxt      = win_we;
               mem_wdata_nxt   = win_wdata;
               mem_req_nxt     = ~mem_req;
               grant_nxt       = win;
               busy_nxt        = 1'b1;
               state_nxt       = WAIT;
               if (win == 3'd0) begin
                  // Only grants that starve someone count against the budget.
                  if (!others_pend)
                     hog_cnt_nxt = '0;
                  else if (hog_cnt != 4'(HOG_LIMIT))
                     hog_cnt_nxt = hog_cnt + 4'd1;
               end else begin
                  hog_cnt_nxt = '0;
                  rr_ptr_nxt  = (win == 3'(NUM_PORTS - 1)) ? 3'd1 : win + 3'd1;
               end
            end
         end
         WAIT: begin
            if (mem_ack == mem_req) begin
               for (int k = 0; k < NUM_PORTS; k++) begin
                  if (grant_o == 3'(k)) begin
                     ack_nxt[k] = ~ack_o[k];
                     if (!mem_we)
                        rdata_nxt[k*16 +: 16] = mem_rdata;
                  end
               end
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= 3'd1;
         hog_cnt     <= '0;
         ack_o       <= '0;
         rdata_o     <= '0;
         mem_req     <= 1'b0;
         mem_address <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         grant_o     <= '0;
         busy_o      <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         hog_cnt     <= hog_cnt_nxt;
         ack_o       <= ack_nxt;
         rdata_o     <= rdata_nxt;
         mem_req     <= mem_req_nxt;
         mem_address <= mem_address_nxt;
         mem_we      <= mem_we_nxt;
         mem_wdata   <= mem_wdata_nxt;
         grant_o     <= grant_nxt;
         busy_o      <= busy_nxt;
      end
   end

endmodule
